// File: rtl/jtframe_arb_pkg.sv
// Shared types and helpers for the SDRAM bank arbiter.
//   arb_state_t : arbiter FSM states
//   OWN_PROG    : owner code for the download (prog) port; banks use their index
//   OWN_NONE    : owner code when nothing is in flight
//   rr_pick     : round-robin winner search over up to four request lines
package jtframe_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam logic [2:0] OWN_PROG = 3'd4;
    localparam logic [2:0] OWN_NONE = 3'd7;

    // First set bit of req at or after ptr, wrapping modulo banks.
    // The loop runs from the far end down so the closest match is written last.
    // Returns ptr when nothing is pending; callers qualify with an "any" flag.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr,
                                           input int         banks);
        logic [1:0] win;
        logic [1:0] idx;
        win = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (k < banks) begin
                idx = 2'((int'(ptr) + k) % banks);
                if (req[idx]) win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin selector.
//   i_req : pending request per bank
//   i_ptr : bank with highest priority this round
//   o_idx : winning bank index (meaningful only when o_any is high)
//   o_any : at least one bank is pending
module jtframe_rr_pick
    import jtframe_arb_pkg::*;
#(
    parameter int BANKS = 4
) (
    input  logic [BANKS-1:0] i_req,
    input  logic [1:0]       i_ptr,
    output logic [1:0]       o_idx,
    output logic             o_any
);

    logic [3:0] w_req4;

    always_comb begin
        w_req4              = '0;
        w_req4[BANKS-1:0]   = i_req;
    end

    assign o_idx = rr_pick(w_req4, i_ptr, BANKS);
    assign o_any = |i_req;

endmodule

// File: rtl/jtframe_bank_arb.sv
// Serialises game bank requests and ROM-download (prog) requests onto the
// single-outstanding request port of the SDRAM controller.
//   clk, rst                     : clock, async active-high reset
//   prog_*                       : download port, absolute priority while prog_en
//   ba_addr/ba_rd/ba_wr          : per-bank requests (write only on bank 0)
//   ba0_din/ba0_din_m            : bank-0 write data and byte mask
//   ba_ack/ba_rdy, prog_ack/rdy  : registered one-cycle accept/complete pulses
//   dout                         : read data, updated on read completion only
//   sd_*                         : controller request port (req held until sd_ack)
module jtframe_bank_arb
    import jtframe_arb_pkg::*;
#(
    parameter int BANKS = 4,
    parameter int AW    = 22,
    parameter int DW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                prog_en,
    input  logic                prog_rd,
    input  logic                prog_we,
    input  logic [AW-1:0]       prog_addr,
    input  logic [1:0]          prog_ba,
    input  logic [DW-1:0]       prog_data,
    input  logic [1:0]          prog_mask,
    output logic                prog_ack,
    output logic                prog_rdy,
    input  logic [BANKS*AW-1:0] ba_addr,
    input  logic [BANKS-1:0]    ba_rd,
    input  logic [BANKS-1:0]    ba_wr,
    input  logic [DW-1:0]       ba0_din,
    input  logic [1:0]          ba0_din_m,
    output logic [BANKS-1:0]    ba_ack,
    output logic [BANKS-1:0]    ba_rdy,
    output logic [DW-1:0]       dout,
    output logic                sd_req,
    output logic                sd_we,
    output logic [1:0]          sd_ba,
    output logic [AW-1:0]       sd_addr,
    output logic [DW-1:0]       sd_din,
    output logic [1:0]          sd_mask,
    input  logic                sd_ack,
    input  logic                sd_rdy,
    input  logic [DW-1:0]       sd_dout
);

    localparam logic [1:0] LAST = 2'(BANKS - 1);

    arb_state_t       r_state, w_state_nx;
    logic [2:0]       r_owner;
    logic [1:0]       r_rr_ptr;
    logic             r_rdy_pend;   // sd_rdy arrived together with sd_ack
    logic [BANKS-1:0] r_ba_ack_d;
    logic             r_prog_ack_d;

    logic [BANKS-1:0] w_ba_pend;
    logic             w_prog_pend;
    logic [1:0]       w_pick;
    logic             w_any;
    logic [AW-1:0]    w_bank_addr;
    logic             w_bank_wr;
    logic             w_grant;
    logic             w_ack_go;
    logic             w_rdy_go;
    logic             w_dout_ld;
    logic             w_unused;

    // Only bank 0 can write; the other ba_wr lines are deliberately dropped.
    assign w_unused = ^{ba_wr, 1'b0};

    // An owner acked last cycle may still show its held level; skip it once.
    always_comb begin
        w_ba_pend    = ba_rd;
        w_ba_pend[0] = ba_rd[0] | ba_wr[0];
        w_ba_pend    = w_ba_pend & ~r_ba_ack_d;
    end

    assign w_prog_pend = prog_en & (prog_rd | prog_we) & ~r_prog_ack_d;

    jtframe_rr_pick #(.BANKS(BANKS)) u_pick (
        .i_req (w_ba_pend),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

    always_comb begin
        w_bank_addr = '0;
        for (int i = 0; i < BANKS; i++)
            if (w_pick == 2'(i)) w_bank_addr = ba_addr[i*AW +: AW];
    end

    assign w_bank_wr = (w_pick == 2'd0) & ba_wr[0];

    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_ack_go   = 1'b0;
        w_rdy_go   = 1'b0;
        case (r_state)
            IDLE: if (w_prog_pend || w_any) begin
                w_grant    = 1'b1;
                w_state_nx = REQ;
            end
            REQ: if (sd_ack) begin
                w_ack_go   = 1'b1;
                w_state_nx = WAIT;
            end
            WAIT: if (sd_rdy || r_rdy_pend) begin
                w_rdy_go   = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Read data is captured when the controller reports it, which is one
    // cycle before rdy when ack and rdy coincide.
    assign w_dout_ld = !sd_we &&
                       ((r_state == REQ  && sd_ack && sd_rdy) ||
                        (r_state == WAIT && sd_rdy && !r_rdy_pend));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= OWN_NONE;
            r_rr_ptr     <= '0;
            r_rdy_pend   <= 1'b0;
            r_ba_ack_d   <= '0;
            r_prog_ack_d <= 1'b0;
            prog_ack     <= 1'b0;
            prog_rdy     <= 1'b0;
            ba_ack       <= '0;
            ba_rdy       <= '0;
            dout         <= '0;
            sd_req       <= 1'b0;
            sd_we        <= 1'b0;
            sd_ba        <= '0;
            sd_addr      <= '0;
            sd_din       <= '0;
            sd_mask      <= '0;
        end else begin
            prog_ack     <= 1'b0;
            prog_rdy     <= 1'b0;
            ba_ack       <= '0;
            ba_rdy       <= '0;
            r_ba_ack_d   <= ba_ack;
            r_prog_ack_d <= prog_ack;

            if (w_grant) begin
                sd_req <= 1'b1;
                if (w_prog_pend) begin
                    r_owner <= OWN_PROG;
                    sd_we   <= prog_we;
                    sd_ba   <= prog_ba;
                    sd_addr <= prog_addr;
                    sd_din  <= prog_data;
                    sd_mask <= prog_mask;
                end else begin
                    r_owner  <= {1'b0, w_pick};
                    sd_we    <= w_bank_wr;
                    sd_ba    <= w_pick;
                    sd_addr  <= w_bank_addr;
                    sd_din   <= ba0_din;
                    sd_mask  <= w_bank_wr ? ba0_din_m : 2'b00;
                    r_rr_ptr <= (w_pick == LAST) ? 2'd0 : w_pick + 2'd1;
                end
            end

            if (w_ack_go) begin
                sd_req     <= 1'b0;
                r_rdy_pend <= sd_rdy;
                if (r_owner == OWN_PROG) prog_ack <= 1'b1;
                for (int i = 0; i < BANKS; i++)
                    if (r_owner == 3'(i)) ba_ack[i] <= 1'b1;
            end

            if (w_rdy_go) begin
                r_rdy_pend <= 1'b0;
                r_owner    <= OWN_NONE;
                if (r_owner == OWN_PROG) prog_rdy <= 1'b1;
                for (int i = 0; i < BANKS; i++)
                    if (r_owner == 3'(i)) ba_rdy[i] <= 1'b1;
            end

            if (w_dout_ld) dout <= sd_dout;
        end
    end

endmodule

// File: tb/tb_jtframe_bank_arb.sv
module tb_jtframe_bank_arb;
    localparam int BANKS = 4;
    localparam int AW    = 22;
    localparam int DW    = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                prog_en = 0, prog_rd = 0, prog_we = 0;
    logic [AW-1:0]       prog_addr = '0;
    logic [1:0]          prog_ba = '0;
    logic [DW-1:0]       prog_data = '0;
    logic [1:0]          prog_mask = '0;
    logic                prog_ack, prog_rdy;
    logic [BANKS*AW-1:0] ba_addr;
    logic [BANKS-1:0]    ba_rd = '0, ba_wr = '0;
    logic [DW-1:0]       ba0_din = '0;
    logic [1:0]          ba0_din_m = '0;
    logic [BANKS-1:0]    ba_ack, ba_rdy;
    logic [DW-1:0]       dout;
    logic                sd_req, sd_we;
    logic [1:0]          sd_ba;
    logic [AW-1:0]       sd_addr;
    logic [DW-1:0]       sd_din;
    logic [1:0]          sd_mask;
    logic                sd_ack = 0, sd_rdy = 0;
    logic [DW-1:0]       sd_dout = '0;

    // controller model knobs
    logic          m_ack_en  = 1'b1;
    int            m_rdy_lat = 3;
    logic [DW-1:0] m_dout    = '0;

    int n_chk = 0;
    int n_err = 0;

    jtframe_bank_arb #(.BANKS(BANKS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .prog_en(prog_en), .prog_rd(prog_rd), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_data(prog_data),
        .prog_mask(prog_mask), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr),
        .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
        .ba_ack(ba_ack), .ba_rdy(ba_rdy), .dout(dout),
        .sd_req(sd_req), .sd_we(sd_we), .sd_ba(sd_ba), .sd_addr(sd_addr),
        .sd_din(sd_din), .sd_mask(sd_mask),
        .sd_ack(sd_ack), .sd_rdy(sd_rdy), .sd_dout(sd_dout)
    );

    always #5 clk = ~clk;

    // SDRAM controller stand-in: acks in the same cycle sd_req is seen,
    // raises sd_rdy m_rdy_lat cycles later (0 = together with ack).
    initial begin
        int cnt;
        cnt = -1;
        forever begin
            @(posedge clk); #1;
            sd_ack  = 1'b0;
            sd_rdy  = 1'b0;
            sd_dout = '0;
            if (rst) begin
                cnt = -1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    sd_rdy  = 1'b1;
                    sd_dout = m_dout;
                    cnt     = -1;
                end
            end else if (sd_req && m_ack_en) begin
                sd_ack = 1'b1;
                if (m_rdy_lat == 0) begin
                    sd_rdy  = 1'b1;
                    sd_dout = m_dout;
                end else begin
                    cnt = m_rdy_lat;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_ack(input string tag, input logic [4:0] exp);
        int n;
        n = 0;
        do begin step(); n++; end while (!(prog_ack || |ba_ack) && n < 40);
        chk(tag, {27'd0, prog_ack, ba_ack}, {27'd0, exp});
    endtask

    task automatic wait_rdy(input string tag, input logic [4:0] exp);
        int n;
        n = 0;
        do begin step(); n++; end while (!(prog_rdy || |ba_rdy) && n < 40);
        chk(tag, {27'd0, prog_rdy, ba_rdy}, {27'd0, exp});
    endtask

    function automatic logic [AW-1:0] baddr(input int i);
        return AW'(22'h3A000 + i * 22'h111);
    endfunction

    initial begin
        int g, b, cnt;
        for (int i = 0; i < BANKS; i++) ba_addr[i*AW +: AW] = baddr(i);

        // reset state
        #12;
        chk("rst_sd_req", {31'd0, sd_req}, 0);
        chk("rst_ack",    {27'd0, prog_ack, ba_ack}, 0);
        chk("rst_rdy",    {27'd0, prog_rdy, ba_rdy}, 0);
        chk("rst_dout",   {16'd0, dout}, 0);
        chk("rst_sd_addr",{10'd0, sd_addr}, 0);
        step();
        rst = 1'b0;
        step();

        // round robin with all banks held
        ba_rd = 4'b1111;
        for (g = 0; g < 5; g++) begin
            b = g % 4;
            m_dout = 16'h1000 + 16'(g);
            wait_ack($sformatf("rr_ack%0d", g), 5'(1 << b));
            chk($sformatf("rr_ba%0d", g), {30'd0, sd_ba}, b);
            chk($sformatf("rr_addr%0d", g), {10'd0, sd_addr}, {10'd0, baddr(b)});
            wait_rdy($sformatf("rr_rdy%0d", g), 5'(1 << b));
            chk($sformatf("rr_dout%0d", g), {16'd0, dout}, 32'h1000 + g);
            if (g == 4) ba_rd = '0;
            step();
            chk($sformatf("rr_rdy_off%0d", g), {28'd0, ba_rdy}, 0);
        end
        step(); step();
        chk("idle_no_req", {31'd0, sd_req}, 0);

        // bank 1 read: latency and data capture
        m_dout = 16'hA5A5;
        ba_rd  = 4'b0010;
        step();
        chk("b1_req_lat", {31'd0, sd_req}, 1);
        chk("b1_ba", {30'd0, sd_ba}, 1);
        wait_ack("b1_ack", 5'b00010);
        ba_rd = '0;
        wait_rdy("b1_rdy", 5'b00010);
        chk("b1_dout", {16'd0, dout}, 32'hA5A5);

        // bank 0 write wins over read, dout untouched
        m_dout    = 16'h1111;
        ba0_din   = 16'hBEEF;
        ba0_din_m = 2'b01;
        ba_rd     = 4'b0001;
        ba_wr     = 4'b0001;
        wait_ack("w0_ack", 5'b00001);
        chk("w0_we",   {31'd0, sd_we}, 1);
        chk("w0_din",  {16'd0, sd_din}, 32'hBEEF);
        chk("w0_mask", {30'd0, sd_mask}, 1);
        ba_rd = '0;
        ba_wr = '0;
        wait_rdy("w0_rdy", 5'b00001);
        chk("w0_dout_kept", {16'd0, dout}, 32'hA5A5);

        // prog priority over a simultaneous bank 2 read
        prog_en   = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 22'h1234;
        prog_ba   = 2'd3;
        prog_data = 16'h5A5A;
        ba_rd     = 4'b0100;
        m_dout    = 16'h2222;
        wait_ack("pg_ack", 5'b10000);
        chk("pg_ba",   {30'd0, sd_ba}, 3);
        chk("pg_addr", {10'd0, sd_addr}, 32'h1234);
        chk("pg_we",   {31'd0, sd_we}, 1);
        chk("pg_din",  {16'd0, sd_din}, 32'h5A5A);
        prog_we = 1'b0;
        wait_rdy("pg_rdy", 5'b10000);
        chk("pg_dout_kept", {16'd0, dout}, 32'hA5A5);
        step();
        wait_ack("pg_b2_ack", 5'b00100);
        chk("pg_b2_addr", {10'd0, sd_addr}, {10'd0, baddr(2)});
        ba_rd = '0;
        wait_rdy("pg_b2_rdy", 5'b00100);
        chk("pg_b2_dout", {16'd0, dout}, 32'h2222);
        prog_en = 1'b0;

        // sd_ack and sd_rdy together: rdy one cycle after ack
        m_rdy_lat = 0;
        m_dout    = 16'h7777;
        ba_rd     = 4'b0010;
        wait_ack("same_ack", 5'b00010);
        ba_rd = '0;
        step();
        chk("same_rdy", {27'd0, prog_rdy, ba_rdy}, 5'b00010);
        chk("same_dout", {16'd0, dout}, 32'h7777);
        m_rdy_lat = 3;
        step();

        // bank 3 drops its request while in WAIT
        ba_rd = 4'b1000;
        wait_ack("b3_ack", 5'b01000);
        ba_rd = '0;
        wait_rdy("b3_rdy", 5'b01000);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sd_req || ba_ack[3]) cnt++;
        end
        chk("b3_no_regrant", cnt, 0);

        // reset while a request is outstanding
        m_ack_en = 1'b0;
        ba_rd    = 4'b0001;
        cnt = 0;
        do begin step(); cnt++; end while (!sd_req && cnt < 20);
        chk("rs_req_up", {31'd0, sd_req}, 1);
        rst = 1'b1;
        #1;
        chk("rs_req_clr", {31'd0, sd_req}, 0);
        chk("rs_ackrdy_clr", {22'd0, prog_ack, ba_ack, prog_rdy, ba_rdy}, 0);
        step(); step();
        rst      = 1'b0;
        m_ack_en = 1'b1;
        ba_rd    = 4'b1111;
        wait_ack("rs_ptr0", 5'b00001);
        ba_rd = '0;
        wait_rdy("rs_rdy", 5'b00001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/jtframe_bank_arb.md
Name: jtframe_bank_arb

Overview:
- Parametrised arbiter that serialises game bank requests and ROM-download (prog) requests onto the single-outstanding request port of the SDRAM controller.
- Generalises the fixed one-bank / four-bank tie-off wiring used at the MiST top level:
  - active bank count is configurable;
  - arbitration between banks is round-robin;
  - the prog port takes priority during download;
  - per-bank ack/rdy routing is registered.
- Sits between the game core and the SDRAM controller inside the frame.

Parameters:
- BANKS, 4, number of active game banks (1..4); bank i maps to SDRAM bank i.
- AW, 22, word address width (22 = 32 MB, 23 = 64 MB).
- DW, 16, data width.

Ports:
- clk  in  1  system clock (SDRAM clock domain).
- rst  in  1  reset, asynchronous, active-high.
- prog_en  in  1  download in progress; prog port has absolute priority while high.
- prog_rd  in  1  prog read request, held until prog_ack.
- prog_we  in  1  prog write request, held until prog_ack.
- prog_addr  in  AW  prog word address.
- prog_ba  in  2  prog SDRAM bank.
- prog_data  in  DW  prog write data.
- prog_mask  in  2  prog byte mask, active-high = byte disabled.
- prog_ack  out  1  one-cycle pulse: prog request accepted.
- prog_rdy  out  1  one-cycle pulse: prog access complete.
- ba_addr  in  BANKS*AW  bank addresses, bank i at [i*AW +: AW].
- ba_rd  in  BANKS  per-bank read request, level, held until ba_ack.
- ba_wr  in  BANKS  per-bank write request; honoured on bank 0 only, ignored elsewhere.
- ba0_din  in  DW  bank-0 write data.
- ba0_din_m  in  2  bank-0 write mask.
- ba_ack  out  BANKS  one-hot one-cycle accept pulse.
- ba_rdy  out  BANKS  one-hot one-cycle completion pulse.
- dout  out  DW  registered read data; valid on the cycle any rdy pulses, held afterwards.
- sd_req  out  1  request to controller, held until sd_ack.
- sd_we  out  1  write qualifier.
- sd_ba  out  2  bank.
- sd_addr  out  AW  address.
- sd_din  out  DW  write data.
- sd_mask  out  2  write mask.
- sd_ack  in  1  controller accepted the request.
- sd_rdy  in  1  controller finished; sd_dout valid for reads.
- sd_dout  in  DW  read data.

Behaviour:
- Reset values (asynchronous assertion of rst): FSM=IDLE, every output 0, round-robin pointer=0, owner=none. Release is synchronous to clk.
- FSM states:
  - IDLE: selects a winner; on the next edge loads sd_* registers, raises sd_req → REQ.
  - REQ: waits for sd_ack; then lowers sd_req and pulses owner's ack → WAIT.
  - WAIT: waits for sd_rdy; then latches dout=sd_dout (reads only) and pulses owner's rdy → IDLE.
- Selection in IDLE:
  - If prog_en and (prog_rd or prog_we): prog wins.
  - Else: the first bank with a pending request, searching from rr_ptr upward modulo BANKS.
  - After a bank grant, rr_ptr = winner+1 mod BANKS. A prog grant leaves rr_ptr unchanged.
- Pending request:
  - bank i: ba_rd[i], or ba_wr[0] when i = 0.
  - prog: prog_rd or prog_we.
  - Owners whose own ack pulsed in the previous cycle are masked for one cycle, so a held level is not double-counted.
- Banks while prog_en is high:
  - prog_en high with no prog request: banks may still be granted.
  - Bank grants are suppressed while prog_en=1 and BANKS>1 only if prog has a pending request. Prog always wins ties.
- Latency:
  - request high in cycle N → sd_req in N+1;
  - sd_ack in M → owner ack in M+1;
  - sd_rdy in K → owner rdy and dout in K+1.
  - Minimum turnaround between back-to-back grants: 1 IDLE cycle.
- Bank-0 write: when both ba_rd[0] and ba_wr[0] are high, the write takes precedence. sd_we=1, sd_din=ba0_din, sd_mask=ba0_din_m; dout unchanged on completion.
- Request dropped before grant: ignored, no ack. Request dropped after grant: the access completes and rdy still pulses (the owner is locked).
- sd_ack and sd_rdy in the same REQ cycle: ack pulses, then rdy pulses on the following cycle, skipping WAIT. Ack is never lost.
- Reset mid-operation: all outputs clear immediately; the in-flight access is abandoned. The controller is reset by the same rst.
- Indices ≥ BANKS do not exist. sd_ba for bank i is the 2-bit constant i.

Decomposition:
- Package jtframe_arb_pkg holds:
  - state enum {IDLE, REQ, WAIT};
  - owner encoding constant OWN_PROG=3'd4 (banks 0..3 are owner = bank index);
  - function rr_pick(req, ptr, BANKS) returning the winner index.
- One sub-module, jtframe_rr_pick: combinational round-robin selector, parametrised on BANKS, unit-testable on its own.

Test Plan:
- BANKS=4, ba_rd=4'b1111 held, sd_ack same cycle as sd_req, sd_rdy 3 cycles later → grant order 0,1,2,3,0; each ba_rdy one-hot for exactly 1 cycle.
- prog_en=1, prog_we=1, prog_addr=22'h1234, ba_rd[2]=1 simultaneously → sd_ba=prog_ba, sd_addr=22'h1234, sd_we=1; prog_ack precedes ba_ack[2].
- ba_wr[0]=1 and ba_rd[0]=1 with ba0_din=16'hBEEF, ba0_din_m=2'b01 → sd_we=1, sd_din=16'hBEEF, sd_mask=2'b01; dout unchanged after rdy.
- Read on bank 1, sd_dout=16'hA5A5 with sd_rdy → dout=16'hA5A5 and ba_rdy=4'b0010 in the next cycle.
- ba_rd[3] dropped in the WAIT state → ba_rdy[3] still pulses once; no further grant to bank 3.
- rst asserted during the REQ state → sd_req=0 and all ack/rdy=0 asynchronously; after release the FSM is in IDLE and rr_ptr=0.
